// File: rtl/flag_pkg.sv
// Shared definitions for the flag register unit: ALU opcode constants,
// update-class enum, flag-vector bit positions and flag-vector width.
// Build option FLAG_OVERFLOW_EN adds the V flag (bit 3), widening the flag
// vector (and each save-stack entry) from 3 to 4 bits.
package flag_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_COMP  = 6'b000011;
  localparam logic [5:0] OP_AND   = 6'b000100;
  localparam logic [5:0] OP_XOR   = 6'b000101;
  localparam logic [5:0] OP_SHIFT = 6'b000110;

  typedef enum logic [1:0] {
    NONE,
    ARITH,
    LOGIC
  } upd_class_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_Z = 2;
`ifdef FLAG_OVERFLOW_EN
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_W = 4;
`else
  localparam int unsigned FLAG_W = 3;
`endif

endpackage

// File: rtl/flag_stack.sv
// LIFO used to save/restore the flag vector across call/return.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, pop       requests (already gated by stall in the parent)
//   din             flag vector to save
//   dout            entry at pointer-1 (valid whenever not empty)
//   pop_ok          pop accepted this cycle; parent loads dout
//   full, empty     registered occupancy status (pointer 0..DEPTH)
//   err             sticky: push on full or pop on empty
// Simultaneous push and pop cancel each other without raising err.
module flag_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pop_ok,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          push_ok;
  logic          bad;

  always_comb begin
    push_ok = push && !pop && !full;
    pop_ok  = pop && !push && !empty;
    bad     = (push && !pop && full) || (pop && !push && empty);
    ptr_nxt = ptr;
    if (push_ok) begin
      ptr_nxt = ptr + PW'(1);
    end else if (pop_ok) begin
      ptr_nxt = ptr - PW'(1);
    end
    wr_idx = AW'(ptr);
    rd_idx = AW'(ptr - PW'(1));
    dout   = mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      full  <= (ptr_nxt == PW'(DEPTH));
      empty <= (ptr_nxt == '0);
      err   <= err || bad;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/flag_register_unit.sv
// Architectural Z/S/C flag register feeding the jump-condition logic.
// Flags latch from a valid, unstalled ALU op one cycle later using a
// per-opcode update class; a flag_stack instance saves/restores flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/opcode/result/carry  retiring ALU op
//   stall                      freeze: ALU op, push and pop ignored
//   flag_push, flag_pop        save / restore flags
//   zero, sign, carry          architectural flags
//   flags_updated              1-cycle pulse after an accepted ALU update
//   stack_full/empty/err       save-stack status (err sticky)
// Build option FLAG_OVERFLOW_EN adds alu_a_msb, alu_b_msb and overflow.
module flag_register_unit
  import flag_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [5:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             stall,
  input  logic             flag_push,
  input  logic             flag_pop,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             flags_updated,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
`ifdef FLAG_OVERFLOW_EN
  ,
  input  logic             alu_a_msb,
  input  logic             alu_b_msb,
  output logic             overflow
`endif
);

  function automatic upd_class_e decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_COMP: return ARITH;
      OP_AND, OP_XOR, OP_SHIFT:         return LOGIC;
      default:                          return NONE;
    endcase
  endfunction

  upd_class_e        cls;
  logic              accept;
  logic              push_req;
  logic              pop_req;
  logic              pop_ok;
  logic [FLAG_W-1:0] flags;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] flags_nxt;
  logic [FLAG_W-1:0] stack_dout;

  always_comb begin
    cls      = decode_class(alu_opcode);
    accept   = alu_valid && !stall && (cls != NONE);
    push_req = flag_push && !stall;
    pop_req  = flag_pop && !stall;

    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_result == '0);
    alu_flags[FLAG_S] = alu_result[WIDTH-1];
    alu_flags[FLAG_C] = (cls == ARITH) && alu_carry;
`ifdef FLAG_OVERFLOW_EN
    if (alu_opcode == OP_ADD || alu_opcode == OP_ADDI) begin
      alu_flags[FLAG_V] = (alu_a_msb == alu_b_msb) && (alu_result[WIDTH-1] != alu_a_msb);
    end else if (alu_opcode == OP_SUB || alu_opcode == OP_COMP) begin
      alu_flags[FLAG_V] = (alu_a_msb != alu_b_msb) && (alu_result[WIDTH-1] != alu_a_msb);
    end
`endif

    // ALU update takes priority over a same-cycle restore.
    flags_nxt = flags;
    if (accept) begin
      flags_nxt = alu_flags;
    end else if (pop_ok) begin
      flags_nxt = stack_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags         <= '0;
      flags_updated <= 1'b0;
    end else begin
      flags         <= flags_nxt;
      flags_updated <= accept;
    end
  end

  // Push stores the registered (pre-update) flags.
  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (FLAG_W)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_req),
    .pop    (pop_req),
    .din    (flags),
    .dout   (stack_dout),
    .pop_ok (pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stack_err)
  );

  assign zero  = flags[FLAG_Z];
  assign sign  = flags[FLAG_S];
  assign carry = flags[FLAG_C];
`ifdef FLAG_OVERFLOW_EN
  assign overflow = flags[FLAG_V];
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
module tb_flag_register_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        stall;
  logic        flag_push;
  logic        flag_pop;
  logic        zero, sign, carry, flags_updated;
  logic        stack_full, stack_empty, stack_err;
  logic        ov;
`ifdef FLAG_OVERFLOW_EN
  logic        am, bm, overflow;
  assign ov = overflow;
`else
  assign ov = 1'b0;
`endif

  always #5 clk = ~clk;

  flag_register_unit #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .stall         (stall),
    .flag_push     (flag_push),
    .flag_pop      (flag_pop),
    .zero          (zero),
    .sign          (sign),
    .carry         (carry),
    .flags_updated (flags_updated),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .stack_err     (stack_err)
`ifdef FLAG_OVERFLOW_EN
    ,
    .alu_a_msb     (am),
    .alu_b_msb     (bm),
    .overflow      (overflow)
`endif
  );

  // Reference model: flags as plain bits, the save stack as a queue of {V,Z,S,C}.
  bit       m_z, m_s, m_c, m_v, m_upd, m_err;
  bit [3:0] q[$];
  int       checks = 0;
  int       errors = 0;

  logic [7:0] obs;
  assign obs = {zero, sign, carry, ov, flags_updated, stack_full, stack_empty, stack_err};

  function automatic logic [7:0] model_vec();
    return {m_z, m_s, m_c, m_v, m_upd, (q.size() == DEPTH), (q.size() == 0), m_err};
  endfunction

  task automatic model_reset();
    {m_z, m_s, m_c, m_v, m_upd, m_err} = '0;
    q.delete();
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_opcode = '0; alu_result = '0; alu_carry = 0;
    stall = 0; flag_push = 0; flag_pop = 0;
  endtask

  // Drive one cycle of stimulus, advance past the edge, update the model.
  task automatic step(input bit v, input logic [5:0] op, input logic [31:0] res,
                      input bit cy, input bit st, input bit pu, input bit po);
    bit       acc, have;
    bit [3:0] popv;
    alu_valid = v; alu_opcode = op; alu_result = res; alu_carry = cy;
    stall = st; flag_push = pu; flag_pop = po;
`ifdef FLAG_OVERFLOW_EN
    am = 1'($urandom); bm = 1'($urandom);
`endif
    @(posedge clk);
    acc  = v && !st && (op <= 6);
    have = 0;
    popv = '0;
    if (!st && pu && !po) begin
      if (q.size() == DEPTH) m_err = 1;
      else q.push_back({m_v, m_z, m_s, m_c});
    end
    if (!st && po && !pu) begin
      if (q.size() == 0) m_err = 1;
      else begin popv = q.pop_back(); have = 1; end
    end
    if (acc) begin
      m_z = (res == 0);
      m_s = res[31];
      m_c = (op <= 3) && cy;
`ifdef FLAG_OVERFLOW_EN
      if (op == 0 || op == 2)      m_v = (am == bm) && (res[31] != am);
      else if (op == 1 || op == 3) m_v = (am != bm) && (res[31] != am);
      else                         m_v = 0;
`endif
    end else if (have) begin
      {m_v, m_z, m_s, m_c} = popv;
    end
    m_upd = acc;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 8'b0000_0010) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 8'b0000_0010);
    end
    rst_n = 1;
    model_reset();
    step(0, 6'd0, 32'd0, 0, 0, 0, 0);
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", obs, model_vec());
    end
  endtask

  typedef struct packed {
    bit          v;
    logic [5:0]  op;
    logic [31:0] res;
    bit          cy;
    bit          st;
    bit          pu;
    bit          po;
  } stim_t;

  task automatic test_directed();
    stim_t t[$];
    t.push_back('{1, 6'b000000, 32'h0000_0000, 1, 0, 0, 0}); // ADD -> Z=1 C=1
    t.push_back('{0, 6'b000000, 32'h0000_0000, 0, 0, 0, 0}); // pulse drops
    t.push_back('{1, 6'b000101, 32'h8000_0000, 1, 0, 0, 0}); // XOR -> S=1 C=0
    t.push_back('{1, 6'b001000, 32'h0000_0000, 1, 0, 0, 0}); // branch holds
    t.push_back('{1, 6'b000001, 32'h0000_0000, 0, 1, 0, 0}); // stalled SUB
    t.push_back('{1, 6'b000001, 32'h0000_0000, 0, 0, 0, 0}); // SUB -> Z=1
    t.push_back('{1, 6'b000000, 32'h0000_0000, 1, 0, 0, 0}); // flags 101
    t.push_back('{1, 6'b000000, 32'h8000_0000, 0, 0, 1, 0}); // push 101 + ADD 010
    t.push_back('{0, 6'b000000, 32'h0000_0000, 0, 0, 0, 1}); // pop -> 101
    for (int i = 0; i < 4; i++) t.push_back('{0, 6'd0, 32'd0, 0, 0, 1, 0});
    t.push_back('{0, 6'd0, 32'd0, 0, 0, 1, 0});              // push on full
    t.push_back('{0, 6'd0, 32'd0, 0, 0, 1, 1});              // push+pop cancel
    t.push_back('{0, 6'd0, 32'd0, 0, 1, 0, 1});              // stalled pop
    for (int i = 0; i < 4; i++) t.push_back('{0, 6'd0, 32'd0, 0, 0, 0, 1});
    t.push_back('{0, 6'd0, 32'd0, 0, 0, 0, 1});              // pop on empty
    t.push_back('{1, 6'b000100, 32'h0000_0001, 1, 0, 1, 0}); // push + AND
    t.push_back('{1, 6'b000011, 32'h0000_0000, 1, 0, 0, 1}); // pop + COMP: ALU wins
    t.push_back('{1, 6'b000110, 32'hFFFF_FFFF, 1, 0, 0, 0}); // SHIFT clears C
    for (int i = 0; i < t.size(); i++) begin
      step(t[i].v, t[i].op, t[i].res, t[i].cy, t[i].st, t[i].pu, t[i].po);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL directed[%0d]: got %b expected %b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       res = 32'h0;
        1:       res = 32'h8000_0000 | 32'($urandom_range(0, 15));
        default: res = $urandom;
      endcase
      step($urandom_range(0, 9) < 7, 6'($urandom_range(0, 15)), res, 1'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    model_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step(1, 6'b000000, 32'h8000_0000, 1, 0, 1, 0);
    step(1, 6'b000000, 32'h0000_0000, 1, 0, 1, 0);
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL async_pre: got %b expected %b", obs, model_vec());
    end
    // Pending update and push, then reset between clock edges.
    alu_valid = 1; alu_opcode = 6'b000001; alu_result = 32'hFFFF_FFFF;
    flag_push = 1;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 8'b0000_0010) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs, 8'b0000_0010);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    model_reset();
    step(0, 6'd0, 32'd0, 0, 0, 0, 1); // pop after reset must flag empty error
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL async_cold: got %b expected %b", obs, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
- Producer side of the branch-condition interface: owns the architectural zero/sign/carry flags that the jump-condition logic consumes.
- Latches flags from ALU results, one cycle after a valid ALU op, using a per-opcode update mask.
- Holds a small save/restore stack so flags survive call/return sequences.
- Sits between the ALU output stage and the jump-condition/PC-select logic.

Parameters:
- WIDTH, 32, ALU result width in bits.
- STACK_DEPTH, 4, number of flag-save entries (power of 2, ≥2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result and opcode valid this cycle.
- alu_opcode  input  6  opcode of the retiring ALU instruction.
- alu_result  input  WIDTH  ALU result.
- alu_carry  input  1  ALU carry-out.
- stall  input  1  freeze; no update, push or pop is accepted.
- flag_push  input  1  save current flags (call).
- flag_pop  input  1  restore flags (return).
- zero  output  1  Z flag.
- sign  output  1  S flag.
- carry  output  1  C flag.
- flags_updated  output  1  one-cycle pulse; flags changed by an ALU op.
- stack_full  output  1  all STACK_DEPTH entries used.
- stack_empty  output  1  no entries used.
- stack_err  output  1  sticky: push on full or pop on empty.

Behaviour:
- Reset (asynchronous, rst_n=0): zero=0, sign=0, carry=0, flags_updated=0, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Reset mid-operation: abandons the pending update; the first clock after rst_n rises behaves as cold start.
- Update classes, decoded from alu_opcode:
  - ARITH (ADD 000000, SUB 000001, ADDI 000010, COMP 000011): Z=(result==0), S=result[WIDTH-1], C=alu_carry.
  - LOGIC (AND 000100, XOR 000101, SHIFT 000110): Z and S as for ARITH; C cleared to 0.
  - NONE (all other opcodes, including branch opcodes 000111–001110): flags held.
- Latency: an accepted ALU op in cycle N (alu_valid=1, stall=0, class≠NONE) is visible on the flag outputs and flags_updated=1 in cycle N+1. flags_updated is 0 in all other cycles.
- stall=1: the ALU op, push and pop are all ignored. Flags, stack pointer and flags_updated (forced 0) behave as an idle cycle.
- Push: stores the current registered {Z,S,C} at the stack pointer, then pointer+1.
- Pop: loads {Z,S,C} from entry pointer-1, then pointer-1. Restored flags appear the next cycle; flags_updated stays 0.
- Push and ALU update in the same cycle: push saves the pre-update flags; the update then applies.
- Pop and ALU update in the same cycle: the pointer decrements and the ALU update wins the flag registers; flags_updated=1.
- Push and pop in the same cycle: both ignored, pointer unchanged, stack_err unchanged.
- Push when full, or pop when empty: ignored, pointer unchanged, stack_err set to 1. stack_err clears only on reset.
- stack_full and stack_empty are registered and derived from the pointer (0..STACK_DEPTH). No wrap-around.

Optional Feature:
- Macro FLAG_OVERFLOW_EN.
- Defined:
  - Adds inputs alu_a_msb and alu_b_msb (1 bit each) and output overflow (1 bit).
  - ADD/ADDI: V=(a_msb==b_msb)&&(result msb!=a_msb).
  - SUB/COMP: V=(a_msb!=b_msb)&&(result msb!=a_msb).
  - LOGIC clears V; NONE holds V.
  - V is pushed and popped with the other flags (4-bit stack entry). Reset value 0.
- Undefined: these ports and V do not exist; the stack entry is 3 bits.

Decomposition:
- Shared package (flag_pkg):
  - 6-bit opcode constants.
  - Update-class enum {NONE, ARITH, LOGIC}.
  - Flag-vector index constants.
  - Flag-vector width, which depends on FLAG_OVERFLOW_EN.
- Sub-module flag_stack: LIFO with pointer, full/empty and error logic.
- Opcode-to-class decode stays inline as a combinational function.

Test Plan:
- Reset then ADD: result=0, carry=1, valid for 1 cycle -> next cycle Z=1, S=0, C=1, flags_updated=1; following cycle flags_updated=0.
- XOR result=32'h8000_0000 after C=1 -> Z=0, S=1, C=0. A following branch opcode 001000 with valid -> flags unchanged, no flags_updated pulse.
- SUB with stall=1 (result=0) -> flags hold, no pulse. Same op with stall=0 -> Z=1 one cycle later.
- Push with {Z,S,C}=101, ADD to 010 in the same cycle -> flags=010. Pop -> flags=101 next cycle, stack_empty=1.
- 4 pushes -> stack_full=1. A 5th push -> stack_err=1, pointer stays 4. 4 pops then a 5th pop -> stack_empty=1, stack_err still 1.
- Assert rst_n low mid-update and mid-push -> all outputs at reset values immediately, without waiting for a clock edge.
